// File: rtl/ex_arb_pkg.sv
// Shared cpu definitions: ALU op encoding, byte width, and arbiter state/owner types.
// Latency: none (types, constants and helpers only).
// Backpressure: not applicable.
`ifndef BYTE
`define BYTE 8
`endif

package ex_arb_pkg;

  localparam int DATA_W = 16;
  localparam int STAT_W = `BYTE;

  // Grant one-hot bit positions
  localparam int GNT_DEC = 0;
  localparam int GNT_AGU = 1;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_t;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_DEC, OWN_AGU}   arb_owner_t;

  // 16-bit saturating increment for event counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ex_arb_grant.sv
// Combinational grant for the shared ALU: AGU fixed priority, DEC promoted once starved.
// Latency: 0 cycles (pure combinational).
// Backpressure: no grant at all while a result is held (state other than IDLE).
module ex_arb_grant
  import ex_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              i_dec_valid,
  input  logic              i_agu_valid,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  input  logic              i_flush,
  input  arb_state_t        i_state,
  output logic [1:0]        o_grant
);

  logic w_dec_elig;
  logic w_starved;

  // A flush only kills DEC traffic; AGU stays eligible
  assign w_dec_elig = i_dec_valid && !i_flush;
  assign w_starved  = (i_wait_cnt >= WAIT_W'(MAX_WAIT));

  // Pick at most one requester, only when no result is held
  always_comb begin
    o_grant = 2'b00;
    if (i_state == ARB_IDLE) begin
      if (w_dec_elig && i_agu_valid) begin
        if (w_starved) o_grant[GNT_DEC] = 1'b1;
        else           o_grant[GNT_AGU] = 1'b1;
      end else if (w_dec_elig) begin
        o_grant[GNT_DEC] = 1'b1;
      end else if (i_agu_valid) begin
        o_grant[GNT_AGU] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_arb.sv
// Shares the execute ALU between DEC and AGU; holds one result until its owner takes it (EX_ARB_PERF_EN adds stall counters).
// Latency: accept in cycle N, result valid (and DEC status strobe) at N+1.
// Backpressure: both ready outputs low while a result is held; next grant the cycle after release.
module ex_arb
  import ex_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  // decode requester
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [DATA_W-1:0] dec_op_A_i,
  input  logic [DATA_W-1:0] dec_op_B_i,
  input  alu_op_t           dec_alu_op_i,
  output logic [DATA_W-1:0] dec_res_o,
  output logic              dec_res_valid_o,
  input  logic              dec_res_ready_i,
  // address-generation requester
  input  logic              agu_valid_i,
  output logic              agu_ready_o,
  input  logic [DATA_W-1:0] agu_op_A_i,
  input  logic [DATA_W-1:0] agu_op_B_i,
  input  alu_op_t           agu_alu_op_i,
  output logic [DATA_W-1:0] agu_res_o,
  output logic              agu_res_valid_o,
  input  logic              agu_res_ready_i,
  // ALU
  output logic [DATA_W-1:0] alu_op_A_o,
  output logic [DATA_W-1:0] alu_op_B_o,
  output alu_op_t           alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [STAT_W-1:0] alu_status_i,
  input  logic              alu_status_we_i,
  // status commit
  output logic [STAT_W-1:0] status_reg_o,
  output logic              status_reg_we_o,
  output logic              busy_o
`ifdef EX_ARB_PERF_EN
  ,
  output logic [15:0]       perf_dec_stall_o,
  output logic [15:0]       perf_agu_stall_o
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  logic [DATA_W-1:0] r_dec_res;
  logic [DATA_W-1:0] r_agu_res;
  logic [STAT_W-1:0] r_status;
  logic              r_status_we;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              w_dec_req;
  logic              w_agu_req;
  logic [1:0]        w_grant;

  // Requests are masked while reset is asserted so ready/ALU outputs sit at reset values
  assign w_dec_req = dec_valid_i && rstn_i;
  assign w_agu_req = agu_valid_i && rstn_i;

  ex_arb_grant #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_grant (
    .i_dec_valid (w_dec_req),
    .i_agu_valid (w_agu_req),
    .i_wait_cnt  (r_wait_cnt),
    .i_flush     (flush_i),
    .i_state     (r_state),
    .o_grant     (w_grant)
  );

  assign dec_ready_o     = w_grant[GNT_DEC];
  assign agu_ready_o     = w_grant[GNT_AGU];
  assign dec_res_o       = r_dec_res;
  assign agu_res_o       = r_agu_res;
  assign dec_res_valid_o = (r_state == ARB_RESP) && (r_owner == OWN_DEC);
  assign agu_res_valid_o = (r_state == ARB_RESP) && (r_owner == OWN_AGU);
  assign status_reg_o    = r_status;
  // A flush landing on the strobe cycle cancels the commit of a DEC result being dropped
  assign status_reg_we_o = r_status_we && !flush_i;
  assign busy_o          = (r_state == ARB_RESP);

  // Steer the granted requester's operands onto the ALU; NOP when idle
  always_comb begin
    alu_op_A_o = '0;
    alu_op_B_o = '0;
    alu_op_o   = ALU_NOP;
    if (w_grant[GNT_AGU]) begin
      alu_op_A_o = agu_op_A_i;
      alu_op_B_o = agu_op_B_i;
      alu_op_o   = agu_alu_op_i;
    end else if (w_grant[GNT_DEC]) begin
      alu_op_A_o = dec_op_A_i;
      alu_op_B_o = dec_op_B_i;
      alu_op_o   = dec_alu_op_i;
    end
  end

  // Arbiter FSM: capture result on accept, hold until owner release or DEC flush
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_DEC;
      r_dec_res   <= '0;
      r_agu_res   <= '0;
      r_status    <= '0;
      r_status_we <= 1'b0;
    end else begin
      r_status_we <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant[GNT_DEC]) begin
            r_dec_res <= alu_res_i;
            r_owner   <= OWN_DEC;
            r_state   <= ARB_RESP;
            if (alu_status_we_i) begin
              r_status    <= alu_status_i;
              r_status_we <= 1'b1;
            end
          end else if (w_grant[GNT_AGU]) begin
            // AGU adds never touch the status register
            r_agu_res <= alu_res_i;
            r_owner   <= OWN_AGU;
            r_state   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (r_owner == OWN_DEC) begin
            if (flush_i || dec_res_ready_i) r_state <= ARB_IDLE;
          end else begin
            if (agu_res_ready_i) r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Starvation counter: counts denied DEC cycles, cleared by accept, idle DEC or flush
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wait_cnt <= '0;
    end else if (flush_i || !dec_valid_i || dec_ready_o) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_SAT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

`ifdef EX_ARB_PERF_EN
  logic [15:0] r_perf_dec;
  logic [15:0] r_perf_agu;

  assign perf_dec_stall_o = r_perf_dec;
  assign perf_agu_stall_o = r_perf_agu;

  // Saturating stall counters: requester valid but not granted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_perf_dec <= '0;
      r_perf_agu <= '0;
    end else begin
      if (dec_valid_i && !dec_ready_o) r_perf_dec <= sat_inc16(r_perf_dec);
      if (agu_valid_i && !agu_ready_o) r_perf_agu <= sat_inc16(r_perf_agu);
    end
  end
`endif

endmodule

// File: tb/tb_ex_arb.sv
// Self-checking bench for ex_arb: vector table with scoreboard plus multi-cycle corner sequences.
// Latency: expects results one cycle after accept.
// Backpressure: exercises held results, flush and async reset while a result is held.
module tb_ex_arb;
  import ex_arb_pkg::*;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        dec_valid, dec_ready, dec_res_valid, dec_res_ready;
  logic [15:0] dec_a, dec_b, dec_res;
  alu_op_t     dec_op;
  logic        agu_valid, agu_ready, agu_res_valid, agu_res_ready;
  logic [15:0] agu_a, agu_b, agu_res;
  alu_op_t     agu_op;
  logic [15:0] alu_a, alu_b, alu_res;
  alu_op_t     alu_op;
  logic [7:0]  alu_status, status_reg;
  logic        alu_status_we, status_we, busy;
`ifdef EX_ARB_PERF_EN
  logic [15:0] perf_dec, perf_agu;
`endif

  ex_arb #(.MAX_WAIT(4), .WAIT_W(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .dec_op_A_i(dec_a), .dec_op_B_i(dec_b), .dec_alu_op_i(dec_op),
    .dec_res_o(dec_res), .dec_res_valid_o(dec_res_valid), .dec_res_ready_i(dec_res_ready),
    .agu_valid_i(agu_valid), .agu_ready_o(agu_ready),
    .agu_op_A_i(agu_a), .agu_op_B_i(agu_b), .agu_alu_op_i(agu_op),
    .agu_res_o(agu_res), .agu_res_valid_o(agu_res_valid), .agu_res_ready_i(agu_res_ready),
    .alu_op_A_o(alu_a), .alu_op_B_o(alu_b), .alu_op_o(alu_op),
    .alu_res_i(alu_res), .alu_status_i(alu_status), .alu_status_we_i(alu_status_we),
    .status_reg_o(status_reg), .status_reg_we_o(status_we), .busy_o(busy)
`ifdef EX_ARB_PERF_EN
    , .perf_dec_stall_o(perf_dec), .perf_agu_stall_o(perf_agu)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU driven by the arbiter's operand outputs
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_XOR: alu_res = alu_a ^ alu_b;
      default: alu_res = 16'h0000;
    endcase
  end

  typedef struct {
    logic        agu;
    alu_op_t     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  st;
    logic        swe_in;
    logic [15:0] exp_res;
    logic        exp_swe;
  } vec_t;

  typedef struct {
    logic        agu;
    logic [15:0] res;
    logic        swe;
    logic [7:0]  st;
  } exp_t;

  vec_t vecs[5];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dec_valid = 1'b0; agu_valid = 1'b0;
    dec_res_ready = 1'b0; agu_res_ready = 1'b0;
    alu_status_we = 1'b0; flush = 1'b0;
  endtask

  // One full transaction: request, expect ready, result one cycle later, then release
  task automatic run_vec(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    alu_status = v.st; alu_status_we = v.swe_in;
    if (v.agu) begin
      agu_valid = 1'b1; agu_a = v.a; agu_b = v.b; agu_op = v.op; dec_valid = 1'b0;
    end else begin
      dec_valid = 1'b1; dec_a = v.a; dec_b = v.b; dec_op = v.op; agu_valid = 1'b0;
    end
    @(negedge clk);
    chk("req_ready",   v.agu ? agu_ready : dec_ready, 1);
    chk("other_ready", v.agu ? dec_ready : agu_ready, 0);
    chk("alu_op",      alu_op, v.op);
    sbq.push_back('{v.agu, v.exp_res, v.exp_swe, v.st});
    @(posedge clk); #1;
    dec_valid = 1'b0; agu_valid = 1'b0; alu_status_we = 1'b0;
    if (v.agu) agu_res_ready = 1'b1; else dec_res_ready = 1'b1;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sbq.pop_front();
      chk("res_valid", e.agu ? agu_res_valid : dec_res_valid, 1);
      chk("res",       e.agu ? agu_res : dec_res, e.res);
      chk("status_we", status_we, e.swe);
      if (e.swe) chk("status_reg", status_reg, e.st);
    end
    @(posedge clk); #1;
    dec_res_ready = 1'b0; agu_res_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_release", busy, 0);
    chk("status_we_one_cycle", status_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp_agu_g;
    logic [5:0] exp_dec_g;

    vecs[0] = '{1'b1, ALU_ADD, 16'h00F0, 16'h0020, 8'hFF, 1'b1, 16'h0110, 1'b0};
    vecs[1] = '{1'b0, ALU_ADD, 16'h1234, 16'h0001, 8'h82, 1'b1, 16'h1235, 1'b1};
    vecs[2] = '{1'b0, ALU_SUB, 16'h0005, 16'h0007, 8'h33, 1'b0, 16'hFFFE, 1'b0};
    vecs[3] = '{1'b1, ALU_AND, 16'hF0F0, 16'h3C3C, 8'h7E, 1'b1, 16'h3030, 1'b0};
    vecs[4] = '{1'b0, ALU_XOR, 16'hFFFF, 16'h00FF, 8'h01, 1'b1, 16'hFF00, 1'b1};

    rstn = 1'b0;
    idle_inputs();
    dec_a = '0; dec_b = '0; dec_op = ALU_NOP;
    agu_a = '0; agu_b = '0; agu_op = ALU_NOP;
    alu_status = '0;

    // Reset values
    #12;
    chk("rst_dec_ready", dec_ready, 0);
    chk("rst_agu_ready", agu_ready, 0);
    chk("rst_dec_res_valid", dec_res_valid, 0);
    chk("rst_agu_res_valid", agu_res_valid, 0);
    chk("rst_dec_res", dec_res, 0);
    chk("rst_agu_res", agu_res, 0);
    chk("rst_status_reg", status_reg, 0);
    chk("rst_status_we", status_we, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, ALU_NOP);
    chk("rst_busy", busy, 0);
    @(negedge clk); rstn = 1'b1;

    // Vector table
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Contention: AGU wins until DEC has waited MAX_WAIT cycles
    exp_agu_g = 6'b000101;
    exp_dec_g = 6'b010000;
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_a = 16'h0010; dec_b = 16'h0003; dec_op = ALU_SUB;
    agu_valid = 1'b1; agu_a = 16'h1000; agu_b = 16'h0200; agu_op = ALU_ADD;
    dec_res_ready = 1'b1; agu_res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("cont_agu_ready_c%0d", c), agu_ready, exp_agu_g[c]);
      chk($sformatf("cont_dec_ready_c%0d", c), dec_ready, exp_dec_g[c]);
      if (c == 5) chk("cont_dec_res", dec_res, 16'h000D);
    end
    @(posedge clk); #1;
    idle_inputs();

    // Backpressure: DEC result held five cycles while AGU waits
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_a = 16'h0100; dec_b = 16'h0023; dec_op = ALU_ADD;
    @(negedge clk);
    chk("bp_dec_ready", dec_ready, 1);
    @(posedge clk); #1;
    dec_valid = 1'b0;
    agu_valid = 1'b1; agu_a = 16'h0F00; agu_b = 16'h00F0; agu_op = ALU_OR;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_busy", busy, 1);
      chk("bp_dec_ready_low", dec_ready, 0);
      chk("bp_agu_ready_low", agu_ready, 0);
      chk("bp_dec_res", dec_res, 16'h0123);
      chk("bp_alu_op_nop", alu_op, ALU_NOP);
    end
    @(posedge clk); #1;
    dec_res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_cycle_agu_ready", agu_ready, 0);
    @(posedge clk); #1;
    dec_res_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_grant", agu_ready, 1);
    @(posedge clk); #1;
    agu_valid = 1'b0; agu_res_ready = 1'b1;
    @(negedge clk);
    chk("bp_agu_res", agu_res, 16'h0FF0);
    @(posedge clk); #1;
    agu_res_ready = 1'b0;

    // Flush in IDLE blocks DEC for that cycle
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_a = 16'h0002; dec_b = 16'h0002; dec_op = ALU_ADD; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_dec_ready", dec_ready, 0);
    chk("flush_idle_alu_op", alu_op, ALU_NOP);
    @(posedge clk); #1;
    flush = 1'b0; dec_res_ready = 1'b1;
    @(negedge clk);
    chk("flush_idle_then_grant", dec_ready, 1);
    @(posedge clk); #1;
    dec_valid = 1'b0;
    @(posedge clk); #1;
    dec_res_ready = 1'b0;

    // Flush during DEC RESP drops the result and the status commit
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_a = 16'h0040; dec_b = 16'h0004; dec_op = ALU_ADD;
    alu_status = 8'h44; alu_status_we = 1'b1;
    @(negedge clk);
    chk("flush_dec_ready", dec_ready, 1);
    @(posedge clk); #1;
    dec_valid = 1'b0; alu_status_we = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_dec_status_we", status_we, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_dec_res_valid", dec_res_valid, 0);
    chk("flush_dec_busy", busy, 0);

    // Flush during AGU RESP has no effect
    @(posedge clk); #1;
    agu_valid = 1'b1; agu_a = 16'h0300; agu_b = 16'h0011; agu_op = ALU_ADD;
    @(negedge clk);
    chk("flush_agu_ready", agu_ready, 1);
    @(posedge clk); #1;
    agu_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_agu_res_valid", agu_res_valid, 1);
    chk("flush_agu_res", agu_res, 16'h0311);
    @(posedge clk); #1;
    agu_res_ready = 1'b1;
    @(posedge clk); #1;
    agu_res_ready = 1'b0;

    // Async reset while a DEC result is held
    @(posedge clk); #1;
    dec_valid = 1'b1; dec_a = 16'h0A00; dec_b = 16'h00B0; dec_op = ALU_ADD;
    alu_status = 8'h55; alu_status_we = 1'b1;
    @(posedge clk); #1;
    dec_valid = 1'b0; alu_status_we = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("arst_dec_res_valid", dec_res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_status_we", status_we, 0);
    chk("arst_status_reg", status_reg, 0);
    chk("arst_dec_res", dec_res, 0);
    chk("arst_alu_op", alu_op, ALU_NOP);
    @(negedge clk); rstn = 1'b1;
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
